// File: rtl/seq_mult_if.sv
// Handshake and operand/result bundle for the iterative shift-add multiplier.
interface seq_mult_if #(
  parameter int unsigned N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] prod;

  modport master (
    output start, a, b,
    input  busy, done, prod
  );

  modport slave (
    input  start, a, b,
    output busy, done, prod
  );
endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, N+1 cycles from
// accepted start to done, optional two's-complement mode via sign/magnitude.
module seq_mult #(
  parameter int unsigned N      = 4,
  parameter bit          SIGNED = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  seq_mult_if.slave bus
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] mcand_q;
  logic [N-1:0]  mplier_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic          busy_q;
  logic          done_q;
  logic [PW-1:0] prod_q;

  logic [N-1:0]  mag_a_d;
  logic [N-1:0]  mag_b_d;
  logic          neg_d;
  logic [PW-1:0] acc_d;
  logic [PW-1:0] result_d;

  // Operand magnitudes and result sign at capture; next accumulator; sign-corrected result.
  always_comb begin
    mag_a_d  = bus.a;
    mag_b_d  = bus.b;
    neg_d    = 1'b0;
    if (SIGNED) begin
      mag_a_d = bus.a[N-1] ? N'(~bus.a + N'(1)) : bus.a;
      mag_b_d = bus.b[N-1] ? N'(~bus.b + N'(1)) : bus.b;
      neg_d   = bus.a[N-1] ^ bus.b[N-1];
    end
    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    result_d = neg_q ? PW'(~acc_q + PW'(1)) : acc_q;
  end

  // Control FSM and datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      prod_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q  <= PW'(mag_a_d);
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= CW'(N);
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          prod_q  <= result_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: four instances (N=4/8, unsigned/signed) driven in parallel
// from shared operands, checked against an integer-arithmetic reference.
module tb_seq_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_mult_if #(.N(4)) if_u4 ();
  seq_mult_if #(.N(4)) if_s4 ();
  seq_mult_if #(.N(8)) if_u8 ();
  seq_mult_if #(.N(8)) if_s8 ();

  assign if_u4.start = start;
  assign if_u4.a     = a_in[3:0];
  assign if_u4.b     = b_in[3:0];
  assign if_s4.start = start;
  assign if_s4.a     = a_in[3:0];
  assign if_s4.b     = b_in[3:0];
  assign if_u8.start = start;
  assign if_u8.a     = a_in;
  assign if_u8.b     = b_in;
  assign if_s8.start = start;
  assign if_s8.a     = a_in;
  assign if_s8.b     = b_in;

  seq_mult #(.N(4), .SIGNED(1'b0)) dut_u4 (.clk(clk), .rst_n(rst_n), .bus(if_u4));
  seq_mult #(.N(4), .SIGNED(1'b1)) dut_s4 (.clk(clk), .rst_n(rst_n), .bus(if_s4));
  seq_mult #(.N(8), .SIGNED(1'b0)) dut_u8 (.clk(clk), .rst_n(rst_n), .bus(if_u8));
  seq_mult #(.N(8), .SIGNED(1'b1)) dut_s8 (.clk(clk), .rst_n(rst_n), .bus(if_s8));

  // Index 0=u4, 1=s4, 2=u8, 3=s8.
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [15:0] prod_v [4];

  assign busy_v    = {if_s8.busy, if_u8.busy, if_s4.busy, if_u4.busy};
  assign done_v    = {if_s8.done, if_u8.done, if_s4.done, if_u4.done};
  assign prod_v[0] = {8'h00, if_u4.prod};
  assign prod_v[1] = {8'h00, if_s4.prod};
  assign prod_v[2] = if_u8.prod;
  assign prod_v[3] = if_s8.prod;

  function automatic int width_of(input int i);
    return (i < 2) ? 4 : 8;
  endfunction

  function automatic bit signed_of(input int i);
    return (i % 2) == 1;
  endfunction

  // Reference: integer product of the low n bits, wrapped to 2n bits.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input int n, input bit sgn);
    int ia;
    int ib;
    int p;
    ia = int'(a) & ((1 << n) - 1);
    ib = int'(b) & ((1 << n) - 1);
    if (sgn) begin
      if (ia >= (1 << (n - 1))) ia = ia - (1 << n);
      if (ib >= (1 << (n - 1))) ib = ib - (1 << n);
    end
    p = ia * ib;
    return 16'(p & ((1 << (2 * n)) - 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One multiply on all instances; optional noise toggles operands every cycle
  // and re-pulses start while every instance is still in RUN.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise);
    int          de [4];
    int          dc [4];
    logic [15:0] pa [4];
    logic [15:0] ep [4];
    logic [3:0]  ovl;
    ovl = 4'h0;
    for (int i = 0; i < 4; i++) begin
      de[i] = -1;
      dc[i] = 0;
      pa[i] = 16'h0;
      ep[i] = model(a, b, width_of(i), signed_of(i));
    end
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    for (int e = 0; e <= 12; e++) begin
      if (e == 0) check("busy_after_start", 32'(busy_v), 32'hF);
      ovl = ovl | (busy_v & done_v);
      for (int i = 0; i < 4; i++) begin
        if (done_v[i]) begin
          dc[i]++;
          if (de[i] < 0) de[i] = e;
          pa[i] = prod_v[i];
        end
      end
      if (noise) begin
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        start = (e <= 2);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("latency_%0d a=%0h b=%0h", i, a, b), 32'(de[i]), 32'(width_of(i) + 1));
      check($sformatf("done_count_%0d", i), 32'(dc[i]), 32'd1);
      check($sformatf("prod_%0d a=%0h b=%0h", i, a, b), 32'(pa[i]), 32'(ep[i]));
      check($sformatf("prod_hold_%0d", i), 32'(prod_v[i]), 32'(ep[i]));
    end
    check("busy_done_exclusive", 32'(ovl), 32'h0);
  endtask

  initial begin
    int t_prev;
    int n_done;
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("reset_busy", 32'(busy_v), 32'h0);
    check("reset_done", 32'(done_v), 32'h0);
    for (int i = 0; i < 4; i++) check($sformatf("reset_prod_%0d", i), 32'(prod_v[i]), 32'h0);

    // Directed operand pairs from the plan (low nibble feeds the N=4 instances).
    run_op(8'h05, 8'h02, 1'b0);
    run_op(8'h04, 8'h0A, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0);
    run_op(8'h0D, 8'h05, 1'b0);
    run_op(8'h08, 8'h08, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h08, 8'h07, 1'b0);
    run_op(8'h00, 8'h0F, 1'b0);
    run_op(8'hF8, 8'h07, 1'b1);

    // Start held high: back-to-back results every N+2 cycles on the N=4 instance.
    a_in   = 8'h03;
    b_in   = 8'h03;
    start  = 1'b1;
    t_prev = -1;
    n_done = 0;
    tick();
    for (int c = 0; c < 30; c++) begin
      if (done_v[0]) begin
        n_done++;
        check("held_start_prod", 32'(prod_v[0]), 32'd9);
        if (t_prev >= 0) check("held_start_period", 32'(c - t_prev), 32'd6);
        t_prev = c;
      end
      tick();
    end
    check("held_start_count", 32'(n_done), 32'd5);
    start = 1'b0;
    repeat (12) tick();

    // Reset two cycles into RUN aborts the multiply.
    a_in  = 8'h09;
    b_in  = 8'h09;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy_v), 32'h0);
    check("abort_done", 32'(done_v), 32'h0);
    check("abort_prod_u4", 32'(prod_v[0]), 32'h0);
    check("abort_prod_s8", 32'(prod_v[3]), 32'h0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_v != 4'h0) n_done++;
      tick();
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op(8'h07, 8'h06, 1'b0);

    // Random operands, with and without operand/start noise during RUN.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
